// File: rtl/calc_btn_cond.sv
// Pushbutton conditioning ahead of the calculator opcode encoder: two-flop sync,
// per-button debounce, opcode levels frozen while execute is held, and an execute strobe.

module calc_btn_db #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_i,
  output logic stb_o
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             stb_q, stb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised level agrees with the debounced one restarts the count.
  always_comb begin
    stb_d = stb_q;
    cnt_d = '0;
    if (sync_i != stb_q) begin
      if (cnt_q == CNT_LAST) stb_d = sync_i;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      stb_q <= stb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stb_o = stb_q;
endmodule

module calc_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btnl_raw,
  input  logic btnc_raw,
  input  logic btnr_raw,
  input  logic btnd_raw,
  output logic btnl,
  output logic btnc,
  output logic btnr,
  output logic exec_pulse
);
  // Lane order: 0=left, 1=centre, 2=right, 3=down (execute).
  localparam int NUM_LANES = 4;
  localparam int EXEC      = 3;

  logic [NUM_LANES-1:0] raw, s1_q, s2_q, stb;
  logic [2:0]           sel_q, sel_d;
  logic                 exec_dly_q, pulse_q, pulse_d;

  assign raw = {btnd_raw, btnr_raw, btnc_raw, btnl_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    calc_btn_db #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .sync_i(s2_q[g]),
      .stb_o (stb[g])
    );
  end

  // Opcode levels track only while execute is released, so the strobe always
  // sees a stable opcode; presses made during execute surface after release.
  always_comb begin
    sel_d   = stb[EXEC] ? sel_q : stb[2:0];
    pulse_d = stb[EXEC] & ~exec_dly_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= '0;
      exec_dly_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      exec_dly_q <= stb[EXEC];
      pulse_q    <= pulse_d;
    end
  end

  assign btnl       = sel_q[0];
  assign btnc       = sel_q[1];
  assign btnr       = sel_q[2];
  assign exec_pulse = pulse_q;
endmodule
